// File: rtl/branch_update_unit_pkg.sv
// Shared types and helpers for the branch resolution/update unit:
// 2-bit counter encodings, the saturating update, and FSM states.
package branch_update_unit_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  // One step toward taken (up=1) or not-taken (up=0), clamped at SNT/ST.
  function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic up);
    if (up) return (ctr == ST) ? ST : ctr + 2'd1;
    else return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/branch_update_unit_if.sv
// Fetch-side prediction push channel and execute-side resolution channel.
// A transfer occurs on a rising clk edge where valid && ready are both high;
// valid must not depend on ready, and payload is held stable while valid && !ready.
interface branch_update_unit_if #(
  parameter int LW = 10,
  parameter int GW = 12
);
  logic          pred_valid;
  logic          pred_ready;
  logic [LW-1:0] pred_lidx;
  logic [GW-1:0] pred_gidx;
  logic          pred_l;
  logic          pred_g;
  logic          pred_final;
  logic [31:0]   pred_pc;

  logic          res_valid;
  logic          res_ready;
  logic          res_taken;
  logic [31:0]   res_target;

  modport master (
    output pred_valid, pred_lidx, pred_gidx, pred_l, pred_g, pred_final, pred_pc,
    input  pred_ready,
    output res_valid, res_taken, res_target,
    input  res_ready
  );

  modport slave (
    input  pred_valid, pred_lidx, pred_gidx, pred_l, pred_g, pred_final, pred_pc,
    output pred_ready,
    input  res_valid, res_taken, res_target,
    output res_ready
  );
endinterface

// File: rtl/branch_update_unit_pred_meta_fifo.sv
// In-order prediction metadata queue (pred_meta_fifo): wrap-around pointers plus
// an occupancy count, synchronous flush. A push while full lands only if a pop frees a slot.
module branch_update_unit_pred_meta_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp_q];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked solely by cnt_q.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wp_q] <= din;
  end

endmodule

// File: rtl/branch_update_unit.sv
// Resolution side of the tournament predictor: pops prediction metadata, reads the
// three counter tables, writes saturated updates, pushes history and redirects on mispredict.
module branch_update_unit
  import branch_update_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LW    = 10,
  parameter int GW    = 12,
  parameter int CW    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_update_unit_if.slave bus,
  output logic                rd_en,
  output logic [LW-1:0]       rd_lidx,
  output logic [GW-1:0]       rd_gidx,
  input  logic [1:0]          rd_lctr,
  input  logic [1:0]          rd_gctr,
  input  logic [1:0]          rd_cctr,
  output logic                wr_en,
  output logic [LW-1:0]       wr_lidx,
  output logic [GW-1:0]       wr_gidx,
  output logic [1:0]          wr_lctr,
  output logic [1:0]          wr_gctr,
  output logic [1:0]          wr_cctr,
  output logic                ghr_push,
  output logic                ghr_taken,
  output logic                redirect,
  output logic [31:0]         redirect_pc,
  output logic [CW-1:0]       mispred_cnt,
  output state_t              fsm_state
);
  typedef struct packed {
    logic [LW-1:0] lidx;
    logic [GW-1:0] gidx;
    logic          l;
    logic          g;
    logic          fin;
    logic [31:0]   pc;
  } meta_t;

  meta_t         head, ent_q;
  logic          full, empty, accept, mispred, res_ready_c;
  logic          taken_q;
  logic [31:0]   target_q;
  logic [CW-1:0] cnt_q;
  state_t        state_q, state_d;

  branch_update_unit_pred_meta_fifo #(.DEPTH(DEPTH), .W($bits(meta_t))) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (mispred),
    .push  (bus.pred_valid),
    .pop   (accept),
    .din   ({bus.pred_lidx, bus.pred_gidx, bus.pred_l, bus.pred_g, bus.pred_final, bus.pred_pc}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.pred_ready = !full;
  assign bus.res_ready  = res_ready_c;
  assign accept         = (state_q == IDLE) && bus.res_valid && !empty;
  assign mispred_cnt    = cnt_q;
  assign fsm_state      = state_q;

  always_comb begin
    state_d     = state_q;
    res_ready_c = 1'b0;
    rd_en       = 1'b0;
    rd_lidx     = '0;
    rd_gidx     = '0;
    wr_en       = 1'b0;
    wr_lidx     = '0;
    wr_gidx     = '0;
    wr_lctr     = '0;
    wr_gctr     = '0;
    wr_cctr     = '0;
    ghr_push    = 1'b0;
    ghr_taken   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mispred     = 1'b0;
    case (state_q)
      IDLE: begin
        res_ready_c = !empty;
        if (accept) state_d = RD;
      end
      RD: begin
        rd_en   = 1'b1;
        rd_lidx = ent_q.lidx;
        rd_gidx = ent_q.gidx;
        state_d = WR;
      end
      WR: begin
        wr_en     = 1'b1;
        wr_lidx   = ent_q.lidx;
        wr_gidx   = ent_q.gidx;
        wr_lctr   = sat_update(rd_lctr, taken_q);
        wr_gctr   = sat_update(rd_gctr, taken_q);
        // Choice only learns when the components disagreed; toward global when global was right.
        wr_cctr   = (ent_q.l == ent_q.g) ? rd_cctr : sat_update(rd_cctr, ent_q.g == taken_q);
        ghr_push  = 1'b1;
        ghr_taken = taken_q;
        mispred   = (ent_q.fin != taken_q);
        redirect  = mispred;
        if (mispred) redirect_pc = taken_q ? target_q : ent_q.pc + 32'd4;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ent_q    <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ent_q    <= head;
        taken_q  <= bus.res_taken;
        target_q <= bus.res_target;
      end
      if (mispred) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_branch_update_unit.sv
// Directed bench for branch_update_unit: a metadata model queue predicts each
// table write, and an expected-write queue is popped when the unit writes.
module tb_branch_update_unit;
  import branch_update_unit_pkg::*;

  localparam int EW = 63;

  typedef struct {
    logic [9:0]  lidx;
    logic [11:0] gidx;
    logic        l;
    logic        g;
    logic        f;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en, wr_en, ghr_push, ghr_taken, redirect;
  logic [9:0]  rd_lidx, wr_lidx;
  logic [11:0] rd_gidx, wr_gidx;
  logic [1:0]  rd_lctr = '0, rd_gctr = '0, rd_cctr = '0;
  logic [1:0]  wr_lctr, wr_gctr, wr_cctr;
  logic [31:0] redirect_pc;
  logic [15:0] mispred_cnt;
  state_t      fsm_state;

  int checks = 0;
  int failures = 0;
  int exp_mis = 0;
  ent_t model_q[$];
  logic [EW-1:0] exp_q[$];

  branch_update_unit_if #(.LW(10), .GW(12)) bus ();

  branch_update_unit #(.DEPTH(4), .LW(10), .GW(12), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rd_en(rd_en), .rd_lidx(rd_lidx), .rd_gidx(rd_gidx),
    .rd_lctr(rd_lctr), .rd_gctr(rd_gctr), .rd_cctr(rd_cctr),
    .wr_en(wr_en), .wr_lidx(wr_lidx), .wr_gidx(wr_gidx),
    .wr_lctr(wr_lctr), .wr_gctr(wr_gctr), .wr_cctr(wr_cctr),
    .ghr_push(ghr_push), .ghr_taken(ghr_taken),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mispred_cnt(mispred_cnt), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_sat(input logic [1:0] c, input bit taken);
    logic [1:0] r;
    if (taken) r = (c == 2'd3) ? 2'd3 : c + 2'd1;
    else r = (c == 2'd0) ? 2'd0 : c - 2'd1;
    return r;
  endfunction

  function automatic logic [EW-1:0] pack(input logic [9:0] li, input logic [11:0] gi,
                                         input logic [1:0] lc, input logic [1:0] gc,
                                         input logic [1:0] cc, input logic rd,
                                         input logic [31:0] rpc, input logic gp,
                                         input logic gt);
    return {li, gi, lc, gc, cc, rd, rpc, gp, gt};
  endfunction

  // driver: one-cycle prediction push
  task automatic push(input logic [9:0] li, input logic [11:0] gi, input bit l,
                      input bit g, input bit f, input logic [31:0] pc);
    ent_t e;
    bus.pred_valid = 1'b1;
    bus.pred_lidx  = li;
    bus.pred_gidx  = gi;
    bus.pred_l     = l;
    bus.pred_g     = g;
    bus.pred_final = f;
    bus.pred_pc    = pc;
    e = '{li, gi, l, g, f, pc};
    if (bus.pred_ready) model_q.push_back(e);
    @(negedge clk);
    bus.pred_valid = 1'b0;
  endtask

  // driver: resolve the oldest branch; a prediction already on the bus is pushed alongside
  task automatic resolve(input bit t, input logic [31:0] tgt, input logic [1:0] lc,
                         input logic [1:0] gc, input logic [1:0] cc);
    ent_t e, np;
    bit ok, mis;
    logic [1:0] ec;
    logic [31:0] rpc;
    ok = 1'b0;
    bus.res_valid  = 1'b1;
    bus.res_taken  = t;
    bus.res_target = tgt;
    rd_lctr = lc;
    rd_gctr = gc;
    rd_cctr = cc;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.res_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      check("res_accept_timeout", 64'(bus.res_ready), 64'(1));
      bus.res_valid = 1'b0;
      return;
    end
    e = model_q.pop_front();
    if (bus.pred_valid) begin
      np = '{bus.pred_lidx, bus.pred_gidx, bus.pred_l, bus.pred_g, bus.pred_final, bus.pred_pc};
      model_q.push_back(np);
    end
    mis = (e.f != t);
    ec  = (e.l == e.g) ? cc : model_sat(cc, e.g == t);
    rpc = !mis ? 32'd0 : (t ? tgt : e.pc + 32'd4);
    exp_q.push_back(pack(e.lidx, e.gidx, model_sat(lc, t), model_sat(gc, t), ec, mis, rpc, 1'b1, t));
    @(negedge clk);
    bus.res_valid  = 1'b0;
    bus.pred_valid = 1'b0;
    check("rd_en", 64'(rd_en), 64'(1));
    check("rd_lidx", 64'(rd_lidx), 64'(e.lidx));
    check("rd_gidx", 64'(rd_gidx), 64'(e.gidx));
    check("wr_en_in_rd", 64'(wr_en), 64'(0));
    @(negedge clk);
    if (wr_en) begin
      check("wr_update",
            64'(pack(wr_lidx, wr_gidx, wr_lctr, wr_gctr, wr_cctr, redirect, redirect_pc, ghr_push, ghr_taken)),
            64'(exp_q.pop_front()));
    end else begin
      check("wr_en_in_wr", 64'(wr_en), 64'(1));
    end
    if (mis) begin
      exp_mis++;
      model_q.delete();
    end
    @(negedge clk);
    check("mispred_cnt", 64'(mispred_cnt), 64'(exp_mis));
    check("rd_en_idle", 64'(rd_en), 64'(0));
  endtask

  initial begin
    bus.pred_valid = 1'b1;
    bus.pred_lidx  = 10'd1;
    bus.pred_gidx  = 12'd1;
    bus.pred_l     = 1'b0;
    bus.pred_g     = 1'b0;
    bus.pred_final = 1'b0;
    bus.pred_pc    = 32'h0;
    bus.res_valid  = 1'b0;
    bus.res_taken  = 1'b0;
    bus.res_target = 32'h0;

    // reset with pushes attempted
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bus.pred_valid = 1'b0;
    check("rst_pred_ready", 64'(bus.pred_ready), 64'(1));
    check("rst_res_ready", 64'(bus.res_ready), 64'(0));
    check("rst_mispred_cnt", 64'(mispred_cnt), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_redirect_pc", 64'(redirect_pc), 64'(0));
    check("rst_state", 64'(fsm_state), 64'(IDLE));

    // correct prediction, global wrong -> choice moves toward local
    push(10'd5, 12'd9, 1'b1, 1'b0, 1'b1, 32'h100);
    resolve(1'b1, 32'h200, 2'd2, 2'd1, 2'd2);

    // mispredict not-taken with two younger entries behind it
    push(10'd5, 12'd9, 1'b1, 1'b0, 1'b1, 32'h100);
    push(10'd7, 12'd11, 1'b0, 1'b0, 1'b0, 32'h110);
    push(10'd8, 12'd12, 1'b1, 1'b1, 1'b1, 32'h120);
    resolve(1'b0, 32'h300, 2'd1, 2'd1, 2'd1);
    check("flush_res_ready", 64'(bus.res_ready), 64'(0));
    check("flush_pred_ready", 64'(bus.pred_ready), 64'(1));

    // saturation at both ends, choice unchanged when components agree
    push(10'd3, 12'd4, 1'b1, 1'b1, 1'b1, 32'h300);
    resolve(1'b1, 32'h340, 2'd3, 2'd3, 2'd2);
    push(10'd1, 12'd2, 1'b0, 1'b0, 1'b0, 32'h400);
    resolve(1'b0, 32'h440, 2'd0, 2'd0, 2'd1);

    // fill, overflow push, then push+pop while full
    for (int i = 0; i < 4; i++)
      push(10'(10 + i), 12'(20 + i), 1'b1, 1'b0, 1'b1, 32'h1000 + 32'(4 * i));
    check("full_pred_ready", 64'(bus.pred_ready), 64'(0));
    push(10'd99, 12'd99, 1'b0, 1'b1, 1'b0, 32'h9999);
    check("full_after_drop", 64'(bus.pred_ready), 64'(0));
    bus.pred_valid = 1'b1;
    bus.pred_lidx  = 10'd14;
    bus.pred_gidx  = 12'd24;
    bus.pred_l     = 1'b0;
    bus.pred_g     = 1'b1;
    bus.pred_final = 1'b1;
    bus.pred_pc    = 32'h1010;
    resolve(1'b1, 32'h2000, 2'(1), 2'(2), 2'(0));
    check("pushpop_full", 64'(bus.pred_ready), 64'(0));
    for (int i = 0; i < 4; i++)
      resolve(1'b1, 32'h2000, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    check("drained_res_ready", 64'(bus.res_ready), 64'(0));

    // resolution held against an empty queue, then an entry arrives (taken mispredict)
    bus.res_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rd_en", 64'(rd_en), 64'(0));
      check("stall_res_ready", 64'(bus.res_ready), 64'(0));
    end
    push(10'd33, 12'd44, 1'b0, 1'b1, 1'b0, 32'h2000);
    check("stall_then_ready", 64'(bus.res_ready), 64'(1));
    resolve(1'b1, 32'h8000, 2'd1, 2'd2, 2'd3);

    // reset during RD abandons the update
    push(10'd50, 12'd60, 1'b1, 1'b1, 1'b0, 32'h3000);
    bus.res_valid = 1'b1;
    check("midrst_res_ready", 64'(bus.res_ready), 64'(1));
    @(negedge clk);
    bus.res_valid = 1'b0;
    check("midrst_rd_en", 64'(rd_en), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_wr_en", 64'(wr_en), 64'(0));
    check("midrst_state", 64'(fsm_state), 64'(IDLE));
    rst_n = 1'b1;
    model_q.delete();
    exp_mis = 0;
    @(negedge clk);
    check("midrst_wr_en2", 64'(wr_en), 64'(0));
    check("midrst_mispred_cnt", 64'(mispred_cnt), 64'(exp_mis));
    check("midrst_res_ready", 64'(bus.res_ready), 64'(0));

    // report
    check("exp_q_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
